// File: rtl/adder_pkg.sv
// Shared constants and helpers for the pipelined segment adder.
package adder_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_SEG   = 8;

  // Number of pipeline stages for a given operand and segment width.
  function automatic int nseg(input int width, input int seg);
    return width / seg;
  endfunction

  // Legal split: at least one segment, with no partial segment left over.
  function automatic bit seg_ok(input int width, input int seg);
    return (seg > 0) && (width >= seg) && ((width % seg) == 0);
  endfunction

  // The package defaults must describe a legal split.
  localparam bit DEF_OK = seg_ok(DEF_WIDTH, DEF_SEG);

  // One full-adder cell; returns {carry_out, sum}.
  function automatic logic [1:0] fa(input logic x, input logic y, input logic c);
    return {(x & y) | (c & (x ^ y)), x ^ y ^ c};
  endfunction

endpackage

// File: rtl/adder_seg_stage.sv
// One pipeline stage: SEG-bit ripple add, with sum, carry, overflow and valid registered.
module adder_seg_stage
  import adder_pkg::*;
#(
  parameter int SEG = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [SEG-1:0] a_seg,
  input  logic [SEG-1:0] b_seg,
  input  logic           ci,
  input  logic           vi,
  output logic [SEG-1:0] s_q,
  output logic           co_q,
  output logic           ovf_q,
  output logic           vo_q
);

  logic [SEG-1:0] s;
  logic           cc;
  logic           cmsb;

  // Ripple chain of full-adder cells; cmsb is the carry into the segment's top bit.
  always_comb begin
    s    = '0;
    cc   = ci;
    cmsb = 1'b0;
    for (int i = 0; i < SEG; i++) begin
      if (i == SEG - 1) cmsb = cc;
      {cc, s[i]} = fa(a_seg[i], b_seg[i], cc);
    end
  end

  // Stage register; holds everything while the pipe is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q   <= '0;
      co_q  <= 1'b0;
      ovf_q <= 1'b0;
      vo_q  <= 1'b0;
    end else if (en) begin
      s_q   <= s;
      co_q  <= cc;
      ovf_q <= cmsb ^ cc;
      vo_q  <= vi;
    end
  end

endmodule

// File: rtl/pipelined_segment_adder.sv
// Pipelined add/subtract: one SEG-bit segment per stage, carry registered between stages.
module pipelined_segment_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG   = DEF_SEG
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSEG = nseg(WIDTH, SEG);

  if (!seg_ok(WIDTH, SEG)) begin : g_bad_split
    $error("pipelined_segment_adder: WIDTH must be a non-zero multiple of SEG");
  end

  logic                             adv;
  logic [NSEG:0]                    vld_pipe;
  logic [NSEG:0]                    cy;
  logic [NSEG-1:0]                  ovf_q;
  logic [NSEG-1:0][SEG-1:0]         seg_q;
  // Skewed operands: level k holds the beat that stage k resolves next.
  logic [NSEG-1:0][WIDTH-1:0]       a_l;
  logic [NSEG-1:0][WIDTH-1:0]       bp_l;
  // Deskewed sum: level k holds the k lowest resolved segments, zeros above.
  logic [NSEG:0][WIDTH-1:0]         s_l;
  logic [NSEG:1][WIDTH-1:0]         s_r;
  logic                             unused_bits;

  // Whole pipe moves together whenever the output slot is empty or draining.
  assign adv      = ~vld_pipe[NSEG] | out_ready;
  assign in_ready = adv;

  assign vld_pipe[0] = in_valid;
  assign cy[0]       = sub | cin;
  assign a_l[0]      = a;
  assign bp_l[0]     = sub ? ~b : b;
  assign s_l[0]      = '0;

  for (genvar k = 0; k < NSEG; k++) begin : g_stg
    adder_seg_stage #(.SEG(SEG)) u_stg (
      .clk   (clk),
      .rst   (rst),
      .en    (adv),
      .a_seg (a_l[k][k*SEG +: SEG]),
      .b_seg (bp_l[k][k*SEG +: SEG]),
      .ci    (cy[k]),
      .vi    (vld_pipe[k]),
      .s_q   (seg_q[k]),
      .co_q  (cy[k+1]),
      .ovf_q (ovf_q[k]),
      .vo_q  (vld_pipe[k+1])
    );

    // Already-resolved low sum bits ride alongside the beat.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)      s_r[k+1] <= '0;
      else if (adv) s_r[k+1] <= s_l[k];
    end

    assign s_l[k+1] = s_r[k+1] | (WIDTH'(seg_q[k]) << (k*SEG));

    if (k < NSEG - 1) begin : g_fwd
      // Unresolved upper operand bits move to the next stage.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_l[k+1]  <= '0;
          bp_l[k+1] <= '0;
        end else if (adv) begin
          a_l[k+1]  <= a_l[k];
          bp_l[k+1] <= bp_l[k];
        end
      end
    end
  end

  assign out_valid = vld_pipe[NSEG];
  assign sum       = s_l[NSEG];
  assign cout      = cy[NSEG];
  assign ovf       = ovf_q[NSEG-1];

  // Low operand bits of the last level and per-stage overflow below the top are dead.
  assign unused_bits = ^{a_l[NSEG-1], bp_l[NSEG-1], ovf_q};

endmodule

// File: tb/tb_pipelined_segment_adder.sv
// Directed bench for pipelined_segment_adder with a queue-based scoreboard.
module tb_pipelined_segment_adder;

  localparam int WIDTH = 32;
  localparam int SEG   = 8;
  localparam int NSEG  = WIDTH / SEG;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    int               t;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             sub = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   chk_lat = 1'b1;
  exp_t q[$];

  pipelined_segment_adder #(.WIDTH(WIDTH), .SEG(SEG)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                 input logic mc, input logic ms);
    exp_t           e;
    logic [WIDTH-1:0] bp;
    logic [WIDTH:0]   full;
    bp     = ms ? ~mb : mb;
    full   = {1'b0, ma} + {1'b0, bp} + (WIDTH+1)'(ms ? 1'b1 : mc);
    e.sum  = full[WIDTH-1:0];
    e.cout = full[WIDTH];
    e.ovf  = (ma[WIDTH-1] == bp[WIDTH-1]) && (full[WIDTH-1] != ma[WIDTH-1]);
    e.t    = 0;
    return e;
  endfunction

  // Present one beat, wait (bounded) for acceptance, record expectation.
  task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                      input logic tc, input logic ts);
    int   n = 0;
    exp_t e;
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("send_timeout", 64'(in_ready), 64'd1);
    else begin
      e   = model(ta, tb, tc, ts);
      e.t = cyc;
      q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("drain_left", 64'(q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  // Retire side: every handshaked result is matched against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_out", 64'(out_valid), 64'd0);
      else begin
        e = q.pop_front();
        chk("sum", 64'(sum), 64'(e.sum));
        chk("cout", 64'(cout), 64'(e.cout));
        chk("ovf", 64'(ovf), 64'(e.ovf));
        if (chk_lat) chk("latency", 64'(cyc - e.t), 64'(NSEG));
      end
    end
  end

  initial begin
    logic [WIDTH-1:0] snap;
    logic             snap_c;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Directed vectors from the plan, one at a time
    send(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0); drain();
    send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0); drain();
    send(32'd5, 32'd7, 1'b0, 1'b1); drain();
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0); drain();
    send(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1); drain();
    send(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0); drain();

    // Back-to-back streaming
    for (int i = 0; i < 8; i++) send(32'(i), 32'(i * 3), 1'b0, 1'b0);
    drain();

    // Backpressure: fill the pipe with the output stalled
    chk_lat   = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < NSEG; i++) send(32'(100 + i), 32'hFFFF_FF00, 1'(i & 1), 1'(i >> 1));
    @(negedge clk);
    snap   = sum;
    snap_c = cout;
    for (int i = 0; i < 5; i++) begin
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      chk("stall_sum", 64'(sum), 64'(snap));
      chk("stall_cout", 64'(cout), 64'(snap_c));
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    // New beats enter while the stalled ones retire
    send(32'hDEAD_BEEF, 32'h0000_0011, 1'b0, 1'b0);
    send(32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1);
    drain();
    chk_lat = 1'b1;

    // Reset mid-flight: everything in flight is dropped
    for (int i = 0; i < 5; i++) send(32'(7 + i), 32'(9), 1'b0, 1'b0);
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_sum", 64'(sum), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("post_rst_idle", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    send(32'd1, 32'd1, 1'b0, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
